// File: rtl/sram_controller_if.sv
// Pipeline-side and SRAM-side signals of the multi-cycle data-memory controller.
// master = pipeline/SRAM environment, slave = controller.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        stall;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, stall, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, stall, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_controller.sv
// Sequences each 32-bit load/store as two 16-bit SRAM phases (low half, then high half)
// with WAIT_CYCLES extra cycles per phase, stalling the pipeline while busy.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input logic               clk,
  input logic               rst,
  sram_controller_if.slave  bus
);

  localparam int unsigned     CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_wr_p0;
  logic [31:0]      off_p0;
  logic [31:0]      wdata_p0;
  logic [31:0]      rdata_p0;

  logic        req;
  logic        phase_end;
  logic        active;
  logic [31:0] off_full;

  assign req       = bus.rd_en | bus.wr_en;
  assign phase_end = (cnt == CNT_LAST);
  assign active    = (state == LO) | (state == HI);
  assign off_full  = bus.address - BASE_ADDR;

  // Acceptance latches op/offset/data; later input changes are ignored until the next IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr_p0 <= 1'b0;
      off_p0   <= '0;
      wdata_p0 <= '0;
      rdata_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= LO;
            cnt      <= '0;
            op_wr_p0 <= bus.wr_en;
            off_p0   <= off_full;
            wdata_p0 <= bus.write_data;
          end
        end
        LO: begin
          if (phase_end) begin
            state <= HI;
            cnt   <= '0;
            if (!op_wr_p0) rdata_p0[15:0] <= bus.sram_dq_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI: begin
          if (phase_end) begin
            state <= DONE;
            cnt   <= '0;
            if (!op_wr_p0) rdata_p0[31:16] <= bus.sram_dq_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // Moore decode: reset forces IDLE, so strobes drop as soon as rst rises.
  assign bus.stall       = active | ((state == IDLE) & req);
  assign bus.ready       = (state == DONE);
  assign bus.read_data   = rdata_p0;
  assign bus.sram_addr   = active ? {off_p0[18:2], (state == HI)} : '0;
  assign bus.sram_dq_out = (active & op_wr_p0) ?
                           ((state == HI) ? wdata_p0[31:16] : wdata_p0[15:0]) : '0;
  assign bus.sram_dq_oe  = active & op_wr_p0;
  assign bus.sram_we_n   = ~(active & op_wr_p0);
  assign bus.sram_oe_n   = ~(active & ~op_wr_p0);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: one instance at WAIT_CYCLES=1 and one at 0, each behind a
// behavioural 16-bit SRAM; read words and written half-words are tracked in scoreboards.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if if1 ();
  sram_controller_if if0 ();

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  logic [15:0] mem1 [0:262143];
  logic [15:0] mem0 [0:262143];
  logic        pl_en;
  int          pl_sel;
  logic [17:0] pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en && pl_sel == 1) mem1[pl_addr] <= pl_data;
    else if (!if1.sram_we_n && if1.sram_dq_oe) mem1[if1.sram_addr] <= if1.sram_dq_out;
  end

  always @(posedge clk) begin
    if (pl_en && pl_sel == 0) mem0[pl_addr] <= pl_data;
    else if (!if0.sram_we_n && if0.sram_dq_oe) mem0[if0.sram_addr] <= if0.sram_dq_out;
  end

  assign if1.sram_dq_in = if1.sram_oe_n ? 16'h0000 : mem1[if1.sram_addr];
  assign if0.sram_dq_in = if0.sram_oe_n ? 16'h0000 : mem0[if0.sram_addr];

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        sel;
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];

  logic        obs_stall [0:31];
  logic        obs_ready [0:31];
  logic        obs_we_n  [0:31];
  logic        obs_oe_n  [0:31];
  logic        obs_dq_oe [0:31];
  logic [17:0] obs_addr  [0:31];
  logic [15:0] obs_dq    [0:31];
  logic [31:0] obs_rdata [0:31];

  task automatic set_inputs(input int sel, input logic wr, input logic rd,
                            input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin
      if1.wr_en = wr; if1.rd_en = rd; if1.address = a; if1.write_data = d;
    end else begin
      if0.wr_en = wr; if0.rd_en = rd; if0.address = a; if0.write_data = d;
    end
  endtask

  task automatic sample(input int sel, input int i);
    if (sel == 1) begin
      obs_stall[i] = if1.stall;     obs_ready[i] = if1.ready;   obs_we_n[i] = if1.sram_we_n;
      obs_oe_n[i]  = if1.sram_oe_n; obs_dq_oe[i] = if1.sram_dq_oe;
      obs_addr[i]  = if1.sram_addr; obs_dq[i]    = if1.sram_dq_out; obs_rdata[i] = if1.read_data;
    end else begin
      obs_stall[i] = if0.stall;     obs_ready[i] = if0.ready;   obs_we_n[i] = if0.sram_we_n;
      obs_oe_n[i]  = if0.sram_oe_n; obs_dq_oe[i] = if0.sram_dq_oe;
      obs_addr[i]  = if0.sram_addr; obs_dq[i]    = if0.sram_dq_out; obs_rdata[i] = if0.read_data;
    end
  endtask

  task automatic preload(input int sel, input logic [17:0] a, input logic [15:0] d);
    pl_sel = sel; pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Called at posedge+1; samples cycles 1..ncyc; request is lowered from cycle drop_at on.
  task automatic drive_access(input int sel, input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input int drop_at, input int ncyc);
    set_inputs(sel, wr, rd, a, d);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      sample(sel, c);
      @(posedge clk); #1;
      if (c + 1 == drop_at) set_inputs(sel, 1'b0, 1'b0, a, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_inputs(1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_inputs(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s, 0);
      vectors++;
      if ({obs_stall[0], obs_ready[0], obs_we_n[0], obs_oe_n[0], obs_dq_oe[0]} !== 5'b00110) begin
        miscompares++;
        $display("FAIL reset_ctl dut%0d: got %b expected 00110", s,
                 {obs_stall[0], obs_ready[0], obs_we_n[0], obs_oe_n[0], obs_dq_oe[0]});
      end
      vectors++;
      if ({obs_rdata[0], obs_addr[0], obs_dq[0]} !== 66'd0) begin
        miscompares++;
        $display("FAIL reset_data dut%0d: got rdata=%h addr=%h dq=%h expected all zero", s,
                 obs_rdata[0], obs_addr[0], obs_dq[0]);
      end
    end
    if1.rd_en = 1'b1;
    #1;
    vectors++;
    if (if1.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_stall_follows_req: got %b expected 1", if1.stall);
    end
    if1.rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    wr_q.push_back('{1'b1, 18'd4, 16'hBEEF});
    wr_q.push_back('{1'b1, 18'd5, 16'hDEAD});
    drive_access(1, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 6, 6);
    for (int c = 1; c <= 6; c++) begin
      logic lo, hi;
      logic [4:0] ectl;
      logic [17:0] ea;
      logic [15:0] ed;
      lo = (c == 2 || c == 3);
      hi = (c == 4 || c == 5);
      ectl = {c <= 5, c == 6, !(lo || hi), 1'b1, lo || hi};
      ea = lo ? 18'd4 : (hi ? 18'd5 : 18'd0);
      ed = lo ? 16'hBEEF : (hi ? 16'hDEAD : 16'h0000);
      vectors++;
      if ({obs_stall[c], obs_ready[c], obs_we_n[c], obs_oe_n[c], obs_dq_oe[c]} !== ectl) begin
        miscompares++;
        $display("FAIL write_ctl c%0d: got %b expected %b", c,
                 {obs_stall[c], obs_ready[c], obs_we_n[c], obs_oe_n[c], obs_dq_oe[c]}, ectl);
      end
      vectors++;
      if ({obs_addr[c], obs_dq[c]} !== {ea, ed}) begin
        miscompares++;
        $display("FAIL write_bus c%0d: got addr=%0d dq=%h expected addr=%0d dq=%h", c,
                 obs_addr[c], obs_dq[c], ea, ed);
      end
    end
    while (wr_q.size() > 0) begin
      wr_t e;
      e = wr_q.pop_front();
      vectors++;
      if ((e.sel ? mem1[e.a] : mem0[e.a]) !== e.d) begin
        miscompares++;
        $display("FAIL write_mem hw%0d: got %h expected %h", e.a, e.sel ? mem1[e.a] : mem0[e.a], e.d);
      end
    end
  endtask

  task automatic test_read();
    preload(1, 18'd4, 16'hBEEF);
    preload(1, 18'd5, 16'hDEAD);
    rd_q.push_back(32'hDEADBEEF);
    drive_access(1, 1'b0, 1'b1, 32'd1032, 32'h0, 6, 6);
    for (int c = 1; c <= 6; c++) begin
      logic lo, hi;
      logic [4:0] ectl;
      logic [17:0] ea;
      lo = (c == 2 || c == 3);
      hi = (c == 4 || c == 5);
      ectl = {c <= 5, c == 6, 1'b1, !(lo || hi), 1'b0};
      ea = lo ? 18'd4 : (hi ? 18'd5 : 18'd0);
      vectors++;
      if ({obs_stall[c], obs_ready[c], obs_we_n[c], obs_oe_n[c], obs_dq_oe[c]} !== ectl) begin
        miscompares++;
        $display("FAIL read_ctl c%0d: got %b expected %b", c,
                 {obs_stall[c], obs_ready[c], obs_we_n[c], obs_oe_n[c], obs_dq_oe[c]}, ectl);
      end
      vectors++;
      if (obs_addr[c] !== ea) begin
        miscompares++;
        $display("FAIL read_addr c%0d: got %0d expected %0d", c, obs_addr[c], ea);
      end
      if (obs_ready[c]) begin
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL read_extra_ready c%0d: got ready with nothing expected", c);
        end else begin
          logic [31:0] ew;
          ew = rd_q.pop_front();
          if (obs_rdata[c] !== ew) begin
            miscompares++;
            $display("FAIL read_data c%0d: got %h expected %h", c, obs_rdata[c], ew);
          end
        end
      end
    end
    vectors++;
    if (obs_rdata[4] !== 32'h0000BEEF) begin
      miscompares++;
      $display("FAIL read_low_capture: got %h expected 0000beef", obs_rdata[4]);
    end
    vectors++;
    if (rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL read_missing_ready: got %0d pending expected 0", rd_q.size());
      rd_q.delete();
    end
  endtask

  task automatic test_priority();
    wr_q.push_back('{1'b1, 18'd8, 16'hF00D});
    wr_q.push_back('{1'b1, 18'd9, 16'hCAFE});
    drive_access(1, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 6, 6);
    for (int c = 2; c <= 5; c++) begin
      vectors++;
      if ({obs_we_n[c], obs_oe_n[c], obs_dq_oe[c]} !== 3'b011) begin
        miscompares++;
        $display("FAIL priority_ctl c%0d: got %b expected 011", c, {obs_we_n[c], obs_oe_n[c], obs_dq_oe[c]});
      end
    end
    vectors++;
    if (obs_rdata[6] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL priority_rdata_hold: got %h expected deadbeef", obs_rdata[6]);
    end
    while (wr_q.size() > 0) begin
      wr_t e;
      e = wr_q.pop_front();
      vectors++;
      if ((e.sel ? mem1[e.a] : mem0[e.a]) !== e.d) begin
        miscompares++;
        $display("FAIL priority_mem hw%0d: got %h expected %h", e.a, e.sel ? mem1[e.a] : mem0[e.a], e.d);
      end
    end
  endtask

  task automatic test_dropped_request();
    int pulses;
    wr_q.push_back('{1'b1, 18'd12, 16'h9BDF});
    wr_q.push_back('{1'b1, 18'd13, 16'h1357});
    drive_access(1, 1'b1, 1'b0, 32'd1048, 32'h13579BDF, 3, 6);
    @(negedge clk);
    sample(1, 7);
    pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      if (obs_ready[c]) pulses++;
      vectors++;
      if (obs_stall[c] !== (c <= 5)) begin
        miscompares++;
        $display("FAIL drop_stall c%0d: got %b expected %b", c, obs_stall[c], c <= 5);
      end
    end
    vectors++;
    if (pulses != 1 || obs_ready[6] !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_ready: got %0d pulses (c6=%b) expected 1 at c6", pulses, obs_ready[6]);
    end
    while (wr_q.size() > 0) begin
      wr_t e;
      e = wr_q.pop_front();
      vectors++;
      if ((e.sel ? mem1[e.a] : mem0[e.a]) !== e.d) begin
        miscompares++;
        $display("FAIL drop_mem hw%0d: got %h expected %h", e.a, e.sel ? mem1[e.a] : mem0[e.a], e.d);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency_w0();
    preload(0, 18'd0, 16'h1234);
    preload(0, 18'd1, 16'h5678);
    rd_q.push_back(32'h56781234);
    drive_access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 4, 4);
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if ({obs_stall[c], obs_ready[c]} !== {c <= 3, c == 4}) begin
        miscompares++;
        $display("FAIL w0_timing c%0d: got stall=%b ready=%b expected %b %b", c,
                 obs_stall[c], obs_ready[c], c <= 3, c == 4);
      end
      if (obs_ready[c]) begin
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL w0_extra_ready c%0d: got ready with nothing expected", c);
        end else begin
          logic [31:0] ew;
          ew = rd_q.pop_front();
          if (obs_rdata[c] !== ew) begin
            miscompares++;
            $display("FAIL w0_read_data c%0d: got %h expected %h", c, obs_rdata[c], ew);
          end
        end
      end
    end
    vectors++;
    if ({obs_oe_n[2], obs_addr[2], obs_oe_n[3], obs_addr[3]} !== {1'b0, 18'd0, 1'b0, 18'd1}) begin
      miscompares++;
      $display("FAIL w0_read_phases: got oe=%b/%b addr=%0d/%0d expected 0/0 addr=0/1",
               obs_oe_n[2], obs_oe_n[3], obs_addr[2], obs_addr[3]);
    end
    rd_q.delete();
    wr_q.push_back('{1'b0, 18'd2, 16'h5555});
    wr_q.push_back('{1'b0, 18'd3, 16'hAAAA});
    drive_access(0, 1'b1, 1'b0, 32'd1028, 32'hAAAA5555, 4, 4);
    vectors++;
    if ({obs_stall[1], obs_stall[2], obs_stall[3], obs_stall[4], obs_ready[4]} !== 5'b11101) begin
      miscompares++;
      $display("FAIL w0_write_timing: got %b expected 11101",
               {obs_stall[1], obs_stall[2], obs_stall[3], obs_stall[4], obs_ready[4]});
    end
    while (wr_q.size() > 0) begin
      wr_t e;
      e = wr_q.pop_front();
      vectors++;
      if ((e.sel ? mem1[e.a] : mem0[e.a]) !== e.d) begin
        miscompares++;
        $display("FAIL w0_mem hw%0d: got %h expected %h", e.a, e.sel ? mem1[e.a] : mem0[e.a], e.d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    rd_q.push_back(32'hDEADBEEF);
    rd_q.push_back(32'hCAFEF00D);
    set_inputs(1, 1'b0, 1'b1, 32'd1032, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      sample(1, c);
      @(posedge clk); #1;
      // Second address wraps past 512 KiB and has nonzero byte-offset bits: still half-words 8/9.
      if (c == 5) set_inputs(1, 1'b0, 1'b1, 32'd1042 + 32'h0008_0000, 32'h0);
      if (c == 11) set_inputs(1, 1'b0, 1'b0, 32'd0, 32'h0);
    end
    first = 0;
    second = 0;
    for (int c = 1; c <= 12; c++) begin
      vectors++;
      if (obs_stall[c] !== !(c == 6 || c == 12)) begin
        miscompares++;
        $display("FAIL b2b_stall c%0d: got %b expected %b", c, obs_stall[c], !(c == 6 || c == 12));
      end
      if (obs_ready[c]) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra_ready c%0d: got ready with nothing expected", c);
        end else begin
          logic [31:0] ew;
          ew = rd_q.pop_front();
          if (obs_rdata[c] !== ew) begin
            miscompares++;
            $display("FAIL b2b_read_data c%0d: got %h expected %h", c, obs_rdata[c], ew);
          end
        end
      end
    end
    vectors++;
    if (first != 6 || second != 12 || rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_ready_spacing: got c%0d and c%0d (%0d pending) expected c6 and c12",
               first, second, rd_q.size());
      rd_q.delete();
    end
  endtask

  task automatic test_reset_mid_access();
    drive_access(1, 1'b1, 1'b0, 32'd1056, 32'h0BADF00D, 0, 3);
    sample(1, 0);
    vectors++;
    if ({obs_we_n[0], obs_dq_oe[0], obs_addr[0], obs_dq[0]} !== {1'b0, 1'b1, 18'd17, 16'h0BAD}) begin
      miscompares++;
      $display("FAIL midrst_in_hi: got we_n=%b oe=%b addr=%0d dq=%h expected 0 1 17 0bad",
               obs_we_n[0], obs_dq_oe[0], obs_addr[0], obs_dq[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    sample(1, 1);
    vectors++;
    if ({obs_we_n[1], obs_dq_oe[1], obs_oe_n[1], obs_ready[1], obs_stall[1]} !== 5'b10101) begin
      miscompares++;
      $display("FAIL midrst_strobes: got %b expected 10101",
               {obs_we_n[1], obs_dq_oe[1], obs_oe_n[1], obs_ready[1], obs_stall[1]});
    end
    vectors++;
    if ({dut1.state, obs_rdata[1], obs_addr[1]} !== {2'd0, 32'd0, 18'd0}) begin
      miscompares++;
      $display("FAIL midrst_state: got state=%0d rdata=%h addr=%0d expected 0 0 0",
               dut1.state, obs_rdata[1], obs_addr[1]);
    end
    vectors++;
    if (mem1[16] !== 16'hF00D) begin
      miscompares++;
      $display("FAIL midrst_low_half: got %h expected f00d", mem1[16]);
    end
    set_inputs(1, 1'b0, 1'b0, 32'd0, 32'h0);
    #1;
    vectors++;
    if (if1.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_stall_idle: got %b expected 0", if1.stall);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pl_en = 1'b0;
    pl_sel = 0;
    pl_addr = '0;
    pl_data = '0;
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_dropped_request();
    test_latency_w0();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
